// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the IF/DM pipeline stages, the memory arbiter and the unified memory.
// The statistics counters exist only when MIPS32_ARB_STATS_EN is defined.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

`ifdef MIPS32_ARB_STATS_EN
  logic [31:0]   if_grant_cnt;
  logic [31:0]   dm_grant_cnt;
  logic [15:0]   starve_force_cnt;
`endif

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
`ifdef MIPS32_ARB_STATS_EN
    , output if_grant_cnt, dm_grant_cnt, starve_force_cnt
`endif
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
`ifdef MIPS32_ARB_STATS_EN
    , input if_grant_cnt, dm_grant_cnt, starve_force_cnt
`endif
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Fixed-priority (DM over IF) arbiter with IF anti-starvation for one single-port memory.
// Optional grant statistics are enabled by defining MIPS32_ARB_STATS_EN.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  mips32_mem_arbiter_if.slave io_bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]    r_state;
  logic [1:0]    r_owner;
  logic [2:0]    r_lat;
  logic [3:0]    r_starve;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  logic w_any_req;
  logic w_forced;
  logic w_if_wins;

  assign w_any_req = io_bus.if_req | io_bus.dm_req;
  assign w_forced  = io_bus.if_req && (r_starve == STARVE_LIM);
  assign w_if_wins = w_forced || (io_bus.if_req && !io_bus.dm_req);

  // NOTE: non-blocking assignments so every register samples the pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_NONE;
      r_lat      <= '0;
      r_starve   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ACCESS;
            if (w_if_wins) begin
              r_owner  <= OWN_IF;
              r_addr   <= io_bus.if_addr;
              r_we     <= 1'b0;
              r_starve <= '0;
            end else begin
              r_owner <= OWN_DM;
              r_addr  <= io_bus.dm_addr;
              r_we    <= io_bus.dm_we;
              r_wdata <= io_bus.dm_wdata;
              // DM only beats a waiting IF while below the limit, so this cannot overflow.
              r_starve <= io_bus.if_req ? r_starve + 4'd1 : 4'd0;
            end
          end
        end
        S_ACCESS: begin
          r_lat   <= LAT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_lat <= r_lat - 3'd1;
          if (r_lat == 3'd1) begin
            if (r_owner == OWN_IF)
              r_if_rdata <= io_bus.mem_rdata;
            else if (!r_we)
              r_dm_rdata <= io_bus.mem_rdata;
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign io_bus.if_gnt    = (r_state == S_ACCESS) && (r_owner == OWN_IF);
  assign io_bus.dm_gnt    = (r_state == S_ACCESS) && (r_owner == OWN_DM);
  assign io_bus.if_rvalid = (r_state == S_RESP) && (r_owner == OWN_IF);
  assign io_bus.dm_done   = (r_state == S_RESP) && (r_owner == OWN_DM);
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.dm_rdata  = r_dm_rdata;
  assign io_bus.mem_en    = (r_state == S_ACCESS);
  assign io_bus.mem_we    = (r_state == S_ACCESS) && r_we;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_wdata = r_wdata;
  assign io_bus.busy      = (r_state != S_IDLE);

`ifdef MIPS32_ARB_STATS_EN
  logic [31:0] r_if_grant_cnt;
  logic [31:0] r_dm_grant_cnt;
  logic [15:0] r_starve_force_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_grant_cnt     <= '0;
      r_dm_grant_cnt     <= '0;
      r_starve_force_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      if (w_if_wins)
        r_if_grant_cnt <= r_if_grant_cnt + 32'd1;
      else
        r_dm_grant_cnt <= r_dm_grant_cnt + 32'd1;
      if (w_forced && (r_starve_force_cnt != 16'hFFFF))
        r_starve_force_cnt <= r_starve_force_cnt + 16'd1;
    end
  end

  assign io_bus.if_grant_cnt     = r_if_grant_cnt;
  assign io_bus.dm_grant_cnt     = r_dm_grant_cnt;
  assign io_bus.starve_force_cnt = r_starve_force_cnt;
`endif
endmodule
